sync_multi_stage: RTL
=====================

Name: sync_multi_stage

Overview:
- Parametrised successor to the team's fixed 3-bit, 2-flop input synchroniser.
- Adds configurable width and stage count (2–4).
- Adds post-sync analysis:
  - Gray-to-binary decode for FIFO pointer crossings.
  - Per-bit rising-edge pulses.
  - Change strobe.
  - Sticky multi-bit-change (Gray violation) error flag.
- Sits at the clock-domain boundary of the async FIFO: receives the foreign-domain Gray pointer or control levels and feeds the local full/empty logic.

Parameters:
- WIDTH, 3, bits per synchronised bus (1..32)
- STAGES, 2, synchroniser flop depth (2..4); values outside this range are a synthesis-time error
- RESET_VAL, 0, reset value of every synchroniser flop and of the history register
- GRAY_CHECK, 1, 1 = enable gray_err detection; 0 = gray_err tied low

Ports:
- clk_in  input  1  destination-domain clock
- reset_n  input  1  asynchronous, active-low reset
- data_in  input  WIDTH  asynchronous source bus (Gray-coded when used as pointer)
- err_clr  input  1  synchronous clear of gray_err
- data_out  output  WIDTH  synchronised value, last flop of chain
- bin_out  output  WIDTH  registered Gray-to-binary decode of data_out
- edge_out  output  WIDTH  per-bit one-cycle pulse on 0->1 transition of data_out
- changed  output  1  one-cycle pulse when data_out differs from previous cycle
- gray_err  output  1  sticky: more than one bit of data_out changed in one cycle

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately):
  - All STAGES chain flops and the history register prev = RESET_VAL.
  - data_out = RESET_VAL; bin_out = gray2bin(RESET_VAL).
  - edge_out = 0, changed = 0, gray_err = 0.
- Reset release: no spurious edge or changed pulse, because prev equals the chain reset value.
- Chain: stage[0] <= data_in; stage[k] <= stage[k-1]; data_out = stage[STAGES-1].
- Chain latency: a data_in change stable for at least one cycle before edge E appears on data_out after exactly STAGES rising edges.
- History: prev <= data_out every cycle.
- Registered outputs, one cycle after data_out (total latency STAGES+1):
  - bin_out <= gray2bin(data_out), where bin[MSB] = g[MSB] and bin[i] = bin[i+1] ^ g[i].
  - edge_out <= data_out & ~prev.
  - changed <= |(data_out ^ prev).
- gray_err:
  - Set (effective next cycle) when GRAY_CHECK=1 and popcount(data_out ^ prev) >= 2.
  - Cleared by err_clr.
  - Simultaneous set and err_clr: set wins.
  - Remains high until cleared; no other state is affected.
- Held input: edge_out and changed are single-cycle and do not repeat while data_in is held.
- Reset mid-operation: all state returns to reset values within the same cycle, with no dependency on the clock; the pipeline refills from data_in over the following STAGES cycles.
- WIDTH=1: bin_out equals data_out (delayed one cycle); gray_err can never set.
- Wrap-around: Gray input 100 -> 000 for WIDTH=3 is a legal single-bit change and sets no error.
- No combinational path from any input to any output.

Decomposition:
- Package sync_pkg:
  - Function gray2bin (WIDTH-generic loop).
  - Function popcount_ge2.
  - Constants SYNC_STAGES_MIN=2 and SYNC_STAGES_MAX=4.
  - RESET_VAL default, shared with the FIFO pointer logic.
- Sub-module sync_chain (parameters WIDTH, STAGES, RESET_VAL): the flop chain only, reusable for single-bit control synchronisers elsewhere in the FIFO.
- Top level instantiates sync_chain and adds the history register, decode, edge/change logic and error flag.

Test Plan (WIDTH=3, STAGES=2, RESET_VAL=0 unless stated):
1. Reset then hold data_in=3'b000 for 10 cycles:
   - data_out=000, bin_out=000.
   - edge_out, changed and gray_err stay 0 throughout, including the release cycle.
2. Drive data_in 000 -> 001 at cycle 0, then hold:
   - data_out=001 at cycle 2.
   - edge_out=001 and changed=1 at cycle 3 only.
   - bin_out=001 from cycle 3.
3. Walk the Gray sequence 000, 001, 011, 010, 110, 111, 101, 100, 000, one value per cycle:
   - bin_out yields 0..7 then 0, lagging by 3 cycles.
   - changed is high every cycle.
   - gray_err stays 0, including the wrap.
4. Step data_in 000 -> 011:
   - gray_err=1 from cycle 3 and held for 20 cycles.
   - err_clr pulse clears it next cycle.
   - Repeating the step with err_clr held high keeps gray_err=1 (set wins).
5. Assert reset_n low mid-walk with data_out=110:
   - All outputs go to reset values immediately, without a clock.
   - After release with data_in=010, data_out=010 after 2 cycles.
6. Re-run tests 2 and 4 with STAGES=4, then WIDTH=8 with GRAY_CHECK=0:
   - Latency becomes 4 (data_out) and 5 (derived outputs).
   - With GRAY_CHECK=0, gray_err never asserts on an 8'h00 -> 8'hFF step.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared helpers for clock-domain-crossing synchronisers.
// Gray decode, change counting, and stage limits used by the FIFO pointer logic.
package sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int SYNC_MAX_WIDTH  = 32;

  localparam logic [SYNC_MAX_WIDTH-1:0] SYNC_RESET_VAL = '0;

  // Zero-extended input decodes correctly: leading zeros stay zero.
  function automatic logic [SYNC_MAX_WIDTH-1:0] gray2bin(
    input logic [SYNC_MAX_WIDTH-1:0] g
  );
    logic [SYNC_MAX_WIDTH-1:0] b;
    b[SYNC_MAX_WIDTH-1] = g[SYNC_MAX_WIDTH-1];
    for (int i = SYNC_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic popcount_ge2(
    input logic [SYNC_MAX_WIDTH-1:0] v
  );
    return |(v & (v - 1'b1));
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchroniser chain.
// Also used on its own for single-bit control crossings.
module sync_chain
  import sync_pkg::*;
#(
  parameter int               WIDTH     = 3,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_chain: STAGES must be 2..4");
  end

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= data_in;
      for (int k = 1; k < STAGES; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign data_out = stage_q[STAGES-1];

endmodule

// File: rtl/sync_multi_stage.sv
// Synchroniser with post-sync Gray decode, edge/change pulses
// and a sticky multi-bit-change error flag.
module sync_multi_stage
  import sync_pkg::*;
#(
  parameter int               WIDTH      = 3,
  parameter int               STAGES     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL  = WIDTH'(SYNC_RESET_VAL),
  parameter bit               GRAY_CHECK = 1'b1
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] edge_out,
  output logic             changed,
  output logic             gray_err
);

  if (WIDTH < 1 || WIDTH > SYNC_MAX_WIDTH) begin : g_bad_width
    $error("sync_multi_stage: WIDTH must be 1..32");
  end

  localparam logic [WIDTH-1:0] BIN_RST =
    WIDTH'(gray2bin(SYNC_MAX_WIDTH'(RESET_VAL)));

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] diff;
  logic             err_set;

  sync_chain #(
    .WIDTH     (WIDTH),
    .STAGES    (STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_chain (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .data_in  (data_in),
    .data_out (sync_q)
  );

  assign diff    = sync_q ^ prev_q;
  assign err_set = GRAY_CHECK &&
                   popcount_ge2(SYNC_MAX_WIDTH'(diff));

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      prev_q   <= RESET_VAL;
      bin_out  <= BIN_RST;
      edge_out <= '0;
      changed  <= 1'b0;
      gray_err <= 1'b0;
    end else begin
      prev_q   <= sync_q;
      bin_out  <= WIDTH'(gray2bin(SYNC_MAX_WIDTH'(sync_q)));
      edge_out <= sync_q & ~prev_q;
      changed  <= |diff;
      // A fresh violation outranks a concurrent clear.
      if (err_set) begin
        gray_err <= 1'b1;
      end else if (err_clr) begin
        gray_err <= 1'b0;
      end
    end
  end

  assign data_out = sync_q;

endmodule
